// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the MIPS instruction-fetch stage.
// Imported by fetch_stage and ifid_reg.
package fetch_pkg;

    localparam int unsigned     PC_W             = 32;
    localparam logic [31:0]     NOP_INSTR        = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [PC_W-1:0] INSTR_BYTES      = 32'd4;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~(INSTR_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// One slice of the IF/ID pipeline register.
// Async active-low reset; clr (bubble) has priority over en.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, imem addressing and the IF/ID pipeline register.
// Optional FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_f,
    input  logic               stall_d,
    input  logic               flush_d,
    input  logic               pc_src_d,
    input  logic [PC_W-1:0]    pc_branch_d,
    input  logic               jump_d,
    input  logic [PC_W-1:0]    jump_target_d,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rd,
    output logic [PC_W-1:0]    pc_f,
    output logic [31:0]        instr_d,
    output logic [PC_W-1:0]    pcplus4_d,
    output logic               valid_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus4;
    logic            ifid_en;

    assign pc_plus4 = pc_q + INSTR_BYTES;

    always_comb begin
        pc_d = pc_plus4;
        if (jump_d) begin
            pc_d = word_align(jump_target_d);
        end else if (pc_src_d) begin
            pc_d = word_align(pc_branch_d);
        end
    end

    // A redirect during stall_f is dropped; the hazard unit never issues one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (!stall_f) begin
            pc_q <= pc_d;
        end
    end

    assign pc_f      = pc_q;
    assign imem_addr = pc_q[IMEM_AW+1:2];
    assign ifid_en   = ~stall_d;

    ifid_reg #(.WIDTH(32)) u_instr (
        .clk   (clk),
        .reset (reset),
        .en    (ifid_en),
        .clr   (flush_d),
        .d     (imem_rd),
        .q     (instr_d)
    );

    ifid_reg #(.WIDTH(PC_W)) u_pcplus4 (
        .clk   (clk),
        .reset (reset),
        .en    (ifid_en),
        .clr   (flush_d),
        .d     (pc_plus4),
        .q     (pcplus4_d)
    );

    ifid_reg #(.WIDTH(1)) u_valid (
        .clk   (clk),
        .reset (reset),
        .en    (ifid_en),
        .clr   (flush_d),
        .d     (1'b1),
        .q     (valid_d)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (!flush_d && !stall_d) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (flush_d || stall_f) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the pipelined MIPS core, directly upstream of the instruction memory.
- Holds the PC and drives the word address into imem. Takes imem's combinational read data and registers it, together with PC+4, into the IF/ID pipeline register for decode.
- Handles stall, flush and branch/jump redirect from the hazard unit and decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 6, imem word-address width; imem_addr = pc_f[IMEM_AW+1:2].

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall_f  in  1  hold PC
- stall_d  in  1  hold IF/ID register
- flush_d  in  1  load bubble into IF/ID
- pc_src_d  in  1  branch taken (resolved in decode)
- pc_branch_d  in  32  branch target
- jump_d  in  1  jump taken
- jump_target_d  in  32  jump target
- imem_addr  out  IMEM_AW  word address to imem
- imem_rd  in  32  instruction word from imem (combinational)
- pc_f  out  32  current fetch PC
- instr_d  out  32  IF/ID instruction
- pcplus4_d  out  32  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction

Behaviour:
- One clock; reset is asynchronous and active-low.
- While reset is low: pc_f=RESET_PC, instr_d=32'h0, pcplus4_d=0, valid_d=0. Assertion mid-operation clears immediately; the first fetch after release is from RESET_PC.
- imem_addr is combinational from pc_f[IMEM_AW+1:2]. PC bits above IMEM_AW+1 are ignored, so addresses wrap modulo 4*2^IMEM_AW bytes.
- Next-PC priority: jump_d > pc_src_d > pc_f+4. The 32-bit add wraps silently at 2^32. Redirect targets have bits [1:0] forced to 00.
- PC register loads next-PC on each edge with stall_f=0 and holds when stall_f=1.
- Redirect asserted while stall_f=1 is ignored. The hazard unit guarantees this does not occur; the bench flags it with an assertion.
- IF/ID register, per edge:
  - flush_d=1: instr_d=32'h0 (sll $0 nop), pcplus4_d=0, valid_d=0. flush_d overrides stall_d.
  - else stall_d=1: hold all IF/ID outputs.
  - else: instr_d=imem_rd, pcplus4_d=pc_f+4, valid_d=1.
- Latency: an instruction at pc_f appears on instr_d one edge later.
- Taken branch/jump costs one bubble; decode/hazard unit asserts flush_d with the redirect.
- Simultaneous stall_f=1, stall_d=0: IF/ID reloads the same instruction (legal, duplicates). The hazard unit normally drives them together.
- No combinational path from any input to imem_addr except via pc_f.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds two outputs, both reset to 0 and wrapping at 2^32:
  - fetch_cnt[31:0]: +1 on every edge where IF/ID loads with valid_d=1.
  - bubble_cnt[31:0]: +1 on every edge where flush_d=1 or stall_f=1.
- When undefined, both ports and counters are absent and the behaviour above is unchanged.

Decomposition:
- Package fetch_pkg: PC_W=32, NOP_INSTR=32'h0000_0000, DEFAULT_RESET_PC, INSTR_BYTES=4.
- One sub-module, ifid_reg: enable+clear register with async active-low reset, parameterised width, instantiated for instr/pcplus4/valid.
- The PC register stays inline.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: bench imem RAM[0]=32'h20020005, RAM[1]=32'h2003000C; release reset, no stalls.
  - Response: pc_f 0→4→8. instr_d=20020005 with pcplus4_d=4 and valid_d=1 after edge 1; then 2003000C with pcplus4_d=8.
- Stall:
  - Stimulus: stall_f=stall_d=1 for 2 cycles at pc_f=8.
  - Response: pc_f, instr_d and pcplus4_d frozen; imem_addr=2 throughout; resume at pc_f=C.
- Branch redirect:
  - Stimulus: pc_src_d=1, pc_branch_d=32'h40, flush_d=1 at pc_f=C.
  - Response: next pc_f=40, imem_addr=16; instr_d=0 and valid_d=0 for one cycle.
- Jump priority:
  - Stimulus: jump_d=1 target 0x80 and pc_src_d=1 target 0x40 together.
  - Response: pc_f=80.
  - Stimulus: target 0x83.
  - Response: pc_f=80.
- Wrap:
  - Stimulus: pc_f=0xFC, IMEM_AW=6.
  - Response: imem_addr=63, next imem_addr=0 while pc_f=0x100.
  - Stimulus: pc_f=0xFFFFFFFC.
  - Response: next pc_f=0.
- Async reset mid-run:
  - Stimulus: pull reset low between edges at pc_f=0x20.
  - Response: pc_f=0 and valid_d=0 immediately, without a clock edge. With FETCH_PERF_CNT_EN, counters also read 0.
